// File: rtl/vdp_super_vram_arbiter.sv
// Slot arbiter for the shared 32-bit super-res VRAM port: one owner per
// 4-clock slot (refresh > display > CPU/CMD round-robin), grants registered.
module vdp_super_vram_arbiter #(
  parameter int REFRESH_SLOT = 180
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [9:0]  cx,
  input  logic        display_window,
  input  logic [16:0] disp_addr,
  output logic [31:0] disp_data,
  output logic        disp_data_valid,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [18:0] cpu_addr,
  input  logic [7:0]  cpu_wdata,
  output logic        cpu_ack,
  output logic [7:0]  cpu_rdata,
  input  logic        cmd_req,
  input  logic        cmd_we,
  input  logic [18:0] cmd_addr,
  input  logic [7:0]  cmd_wdata,
  output logic        cmd_ack,
  output logic [7:0]  cmd_rdata,
  output logic [16:0] mem_addr,
  output logic        mem_we,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  output logic        mem_refresh,
  input  logic [31:0] mem_rdata,
  output logic [2:0]  dbg_owner
);

  // Handshake: a requester raises req with we/addr/wdata stable and holds them
  // until its single-cycle ack; the ack cycle itself never re-grants that requester.
  typedef enum logic [2:0] {
    OWN_IDLE    = 3'd0,
    OWN_REFRESH = 3'd1,
    OWN_DISP    = 3'd2,
    OWN_CPU     = 3'd3,
    OWN_CMD     = 3'd4
  } owner_e;

  localparam logic [7:0] REFRESH_SLOT_W = 8'(REFRESH_SLOT);

  owner_e      owner_q, owner_d, grant;
  logic        last_cmd_q, last_cmd_d;
  logic [1:0]  lane_q, lane_d;
  logic [16:0] mem_addr_q, mem_addr_d;
  logic        mem_we_q, mem_we_d;
  logic [3:0]  mem_be_q, mem_be_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic        mem_refresh_q, mem_refresh_d;
  logic [31:0] disp_data_q, disp_data_d;
  logic        disp_valid_q, disp_valid_d;
  logic        cpu_ack_q, cpu_ack_d, cmd_ack_q, cmd_ack_d;
  logic [7:0]  cpu_rdata_q, cpu_rdata_d, cmd_rdata_q, cmd_rdata_d;

  logic        slot_end, cpu_ok, cmd_ok, pick_cmd, req_we;
  logic [7:0]  next_slot, req_wdata, lane_byte;
  logic [18:0] req_addr;

  always_comb begin
    slot_end  = (cx[1:0] == 2'd3);
    next_slot = cx[9:2] + 8'd1;
    cpu_ok    = cpu_req && (owner_q != OWN_CPU);
    cmd_ok    = cmd_req && (owner_q != OWN_CMD);
    pick_cmd  = cmd_ok && (!cpu_ok || !last_cmd_q);
    req_addr  = pick_cmd ? cmd_addr  : cpu_addr;
    req_we    = pick_cmd ? cmd_we    : cpu_we;
    req_wdata = pick_cmd ? cmd_wdata : cpu_wdata;
    lane_byte = 8'(mem_rdata >> {lane_q, 3'b000});

    grant = OWN_IDLE;
    if (next_slot == REFRESH_SLOT_W)  grant = OWN_REFRESH;
    else if (display_window)          grant = OWN_DISP;
    else if (cpu_ok || cmd_ok)        grant = pick_cmd ? OWN_CMD : OWN_CPU;

    owner_d       = owner_q;
    last_cmd_d    = last_cmd_q;
    lane_d        = lane_q;
    mem_addr_d    = mem_addr_q;
    mem_we_d      = mem_we_q;
    mem_be_d      = mem_be_q;
    mem_wdata_d   = mem_wdata_q;
    mem_refresh_d = mem_refresh_q;
    disp_data_d   = disp_data_q;
    disp_valid_d  = 1'b0;
    cpu_ack_d     = 1'b0;
    cmd_ack_d     = 1'b0;
    cpu_rdata_d   = cpu_rdata_q;
    cmd_rdata_d   = cmd_rdata_q;

    if (slot_end) begin
      // The edge ending phase 3 both retires the current owner and starts the next.
      case (owner_q)
        OWN_DISP: begin
          disp_data_d  = mem_rdata;
          disp_valid_d = 1'b1;
        end
        OWN_CPU: begin
          cpu_ack_d = 1'b1;
          if (!mem_we_q) cpu_rdata_d = lane_byte;
        end
        OWN_CMD: begin
          cmd_ack_d = 1'b1;
          if (!mem_we_q) cmd_rdata_d = lane_byte;
        end
        default: ;
      endcase

      owner_d       = grant;
      mem_we_d      = 1'b0;
      mem_be_d      = 4'h0;
      mem_refresh_d = (grant == OWN_REFRESH);
      case (grant)
        OWN_DISP: begin
          mem_addr_d = disp_addr;
          mem_be_d   = 4'hF;
        end
        OWN_CPU, OWN_CMD: begin
          mem_addr_d  = req_addr[18:2];
          mem_be_d    = 4'b0001 << req_addr[1:0];
          mem_wdata_d = {4{req_wdata}};
          mem_we_d    = req_we;
          lane_d      = req_addr[1:0];
          last_cmd_d  = pick_cmd;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      owner_q       <= OWN_IDLE;
      last_cmd_q    <= 1'b1;
      lane_q        <= 2'd0;
      mem_addr_q    <= '0;
      mem_we_q      <= 1'b0;
      mem_be_q      <= 4'h0;
      mem_wdata_q   <= '0;
      mem_refresh_q <= 1'b0;
      disp_data_q   <= '0;
      disp_valid_q  <= 1'b0;
      cpu_ack_q     <= 1'b0;
      cmd_ack_q     <= 1'b0;
      cpu_rdata_q   <= '0;
      cmd_rdata_q   <= '0;
    end else begin
      owner_q       <= owner_d;
      last_cmd_q    <= last_cmd_d;
      lane_q        <= lane_d;
      mem_addr_q    <= mem_addr_d;
      mem_we_q      <= mem_we_d;
      mem_be_q      <= mem_be_d;
      mem_wdata_q   <= mem_wdata_d;
      mem_refresh_q <= mem_refresh_d;
      disp_data_q   <= disp_data_d;
      disp_valid_q  <= disp_valid_d;
      cpu_ack_q     <= cpu_ack_d;
      cmd_ack_q     <= cmd_ack_d;
      cpu_rdata_q   <= cpu_rdata_d;
      cmd_rdata_q   <= cmd_rdata_d;
    end
  end

  assign mem_addr        = mem_addr_q;
  assign mem_we          = mem_we_q;
  assign mem_be          = mem_be_q;
  assign mem_wdata       = mem_wdata_q;
  assign mem_refresh     = mem_refresh_q;
  assign disp_data       = disp_data_q;
  assign disp_data_valid = disp_valid_q;
  assign cpu_ack         = cpu_ack_q;
  assign cpu_rdata       = cpu_rdata_q;
  assign cmd_ack         = cmd_ack_q;
  assign cmd_rdata       = cmd_rdata_q;
  assign dbg_owner       = owner_q;

endmodule

// File: tb/tb_vdp_super_vram_arbiter.sv
// Directed bench for vdp_super_vram_arbiter: a slot-level model checked every
// cycle, plus hand-computed expectations for each scenario.
module tb_vdp_super_vram_arbiter;

  localparam int REFRESH_SLOT = 180;
  localparam int O_IDLE = 0, O_REF = 1, O_DISP = 2, O_CPU = 3, O_CMD = 4;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [9:0]  cx = '0;
  logic        display_window = 1'b0;
  logic [16:0] disp_addr = '0;
  logic [31:0] disp_data;
  logic        disp_data_valid;
  logic        cpu_req = 1'b0, cpu_we = 1'b0;
  logic [18:0] cpu_addr = '0;
  logic [7:0]  cpu_wdata = '0;
  logic        cpu_ack;
  logic [7:0]  cpu_rdata;
  logic        cmd_req = 1'b0, cmd_we = 1'b0;
  logic [18:0] cmd_addr = '0;
  logic [7:0]  cmd_wdata = '0;
  logic        cmd_ack;
  logic [7:0]  cmd_rdata;
  logic [16:0] mem_addr;
  logic        mem_we;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_refresh;
  logic [31:0] mem_rdata = '0;
  logic [2:0]  dbg_owner;

  int checks = 0;
  int failures = 0;
  logic [31:0] exp_q[$];

  vdp_super_vram_arbiter #(.REFRESH_SLOT(REFRESH_SLOT)) dut (
    .clk(clk), .reset_n(reset_n), .cx(cx), .display_window(display_window),
    .disp_addr(disp_addr), .disp_data(disp_data), .disp_data_valid(disp_data_valid),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
    .cmd_req(cmd_req), .cmd_we(cmd_we), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .cmd_ack(cmd_ack), .cmd_rdata(cmd_rdata),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_be(mem_be), .mem_wdata(mem_wdata),
    .mem_refresh(mem_refresh), .mem_rdata(mem_rdata), .dbg_owner(dbg_owner)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- checking helper ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (cx=%0d t=%0t)", name, act, exp, cx, $time);
    end
  endtask

  // ---------------- slot-level model ----------------
  int          m_owner, m_last, m_nslot;
  logic [1:0]  m_lane;
  logic        m_cur_we, m_cpu_ok, m_cmd_ok, m_w;
  logic [18:0] m_a;
  logic [7:0]  m_d, m_byte;
  logic [16:0] m_addr;
  logic        m_we, m_refresh, m_disp_valid, m_cpu_ack, m_cmd_ack;
  logic [3:0]  m_be;
  logic [31:0] m_wdata, m_disp_data;
  logic [7:0]  m_cpu_rdata, m_cmd_rdata;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_owner = O_IDLE; m_last = O_CMD; m_lane = 2'd0; m_cur_we = 1'b0;
      m_addr = '0; m_we = 1'b0; m_be = 4'h0; m_wdata = '0; m_refresh = 1'b0;
      m_disp_data = '0; m_disp_valid = 1'b0; m_cpu_ack = 1'b0; m_cmd_ack = 1'b0;
      m_cpu_rdata = '0; m_cmd_rdata = '0;
    end else begin
      m_disp_valid = 1'b0; m_cpu_ack = 1'b0; m_cmd_ack = 1'b0;
      if (int'(cx) % 4 == 3) begin
        m_byte = 8'((mem_rdata >> (8 * m_lane)) & 32'hFF);
        if (m_owner == O_DISP) begin m_disp_data = mem_rdata; m_disp_valid = 1'b1; end
        if (m_owner == O_CPU) begin m_cpu_ack = 1'b1; if (!m_cur_we) m_cpu_rdata = m_byte; end
        if (m_owner == O_CMD) begin m_cmd_ack = 1'b1; if (!m_cur_we) m_cmd_rdata = m_byte; end

        m_nslot  = (int'(cx) / 4 + 1) % 256;
        m_cpu_ok = cpu_req && (m_owner != O_CPU);
        m_cmd_ok = cmd_req && (m_owner != O_CMD);
        if (m_nslot == REFRESH_SLOT)  m_owner = O_REF;
        else if (display_window)      m_owner = O_DISP;
        else if (m_cpu_ok && m_cmd_ok) m_owner = (m_last == O_CPU) ? O_CMD : O_CPU;
        else if (m_cpu_ok)            m_owner = O_CPU;
        else if (m_cmd_ok)            m_owner = O_CMD;
        else                          m_owner = O_IDLE;

        m_we = 1'b0; m_be = 4'h0; m_refresh = (m_owner == O_REF);
        if (m_owner == O_DISP) begin m_addr = disp_addr; m_be = 4'hF; end
        if (m_owner == O_CPU || m_owner == O_CMD) begin
          m_last = m_owner;
          m_a = (m_owner == O_CPU) ? cpu_addr  : cmd_addr;
          m_w = (m_owner == O_CPU) ? cpu_we    : cmd_we;
          m_d = (m_owner == O_CPU) ? cpu_wdata : cmd_wdata;
          m_addr = m_a[18:2]; m_lane = m_a[1:0]; m_be = 4'(1 << m_lane);
          m_wdata = {4{m_d}}; m_we = m_w; m_cur_we = m_w;
        end
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    check("mem_addr",        32'(mem_addr),        32'(m_addr));
    check("mem_we",          32'(mem_we),          32'(m_we));
    check("mem_be",          32'(mem_be),          32'(m_be));
    check("mem_wdata",       mem_wdata,            m_wdata);
    check("mem_refresh",     32'(mem_refresh),     32'(m_refresh));
    check("disp_data",       disp_data,            m_disp_data);
    check("disp_data_valid", 32'(disp_data_valid), 32'(m_disp_valid));
    check("cpu_ack",         32'(cpu_ack),         32'(m_cpu_ack));
    check("cpu_rdata",       32'(cpu_rdata),       32'(m_cpu_rdata));
    check("cmd_ack",         32'(cmd_ack),         32'(m_cmd_ack));
    check("cmd_rdata",       32'(cmd_rdata),       32'(m_cmd_rdata));
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(negedge clk);
    cx = cx + 10'd1;
  endtask

  task automatic wait_phase(input logic [1:0] p);
    for (int i = 0; i < 8 && cx[1:0] != p; i++) tick();
  endtask

  task automatic wait_cx(input logic [9:0] v);
    for (int i = 0; i < 1100 && cx != v; i++) tick();
    check("wait_cx_reached", 32'(cx), 32'(v));
  endtask

  task automatic wait_ack(input bit is_cmd, input int budget, output int waited);
    bit seen;
    seen = 1'b0;
    waited = 0;
    while (!seen && waited < budget) begin
      tick();
      waited++;
      seen = is_cmd ? cmd_ack : cpu_ack;
    end
    check(is_cmd ? "cmd_ack_seen" : "cpu_ack_seen", 32'(seen), 32'd1);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog");
  end

  // ---------------- directed stimulus ----------------
  initial begin
    int waited, n_acks;
    repeat (3) tick();
    check("rst_mem_be",    32'(mem_be),    32'h0);
    check("rst_mem_addr",  32'(mem_addr),  32'h0);
    check("rst_dbg_owner", 32'(dbg_owner), 32'h0);
    reset_n = 1'b1;

    // Both requesters held: CPU wins first tie, then strict alternation.
    wait_phase(2'd2);
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 19'h00008; cpu_wdata = 8'h3C;
    cmd_req = 1'b1; cmd_we = 1'b0; cmd_addr = 19'h00011;
    mem_rdata = 32'h11223344;
    exp_q = '{32'd0, 32'd1, 32'd0, 32'd1};
    tick(); tick();
    check("tie_first_be",    32'(mem_be),    32'h1);
    check("tie_first_we",    32'(mem_we),    32'h1);
    check("tie_first_wdata", mem_wdata,      32'h3C3C3C3C);
    n_acks = 0;
    for (int k = 1; k <= 16; k++) begin
      tick();
      if (cpu_ack || cmd_ack) begin
        n_acks++;
        if (exp_q.size() > 0) check("rr_order", 32'(cmd_ack), exp_q.pop_front());
      end
    end
    check("rr_ack_count", 32'(n_acks), 32'd4);
    check("rr_queue_left", 32'(exp_q.size()), 32'd0);
    check("cmd_rdata_lane1", 32'(cmd_rdata), 32'h33);
    cmd_req = 1'b0;
    wait_ack(1'b0, 8, waited);
    cpu_req = 1'b0;

    // CPU write, window closed.
    wait_phase(2'd2);
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 19'h00006; cpu_wdata = 8'hA5;
    tick(); tick();
    for (int p = 0; p < 4; p++) begin
      check("wr_mem_we",    32'(mem_we),   32'h1);
      check("wr_mem_addr",  32'(mem_addr), 32'h1);
      check("wr_mem_be",    32'(mem_be),   32'h4);
      check("wr_mem_wdata", mem_wdata,     32'hA5A5A5A5);
      check("wr_no_ack",    32'(cpu_ack),  32'h0);
      tick();
    end
    check("wr_ack",        32'(cpu_ack), 32'h1);
    check("wr_we_dropped", 32'(mem_we),  32'h0);
    cpu_req = 1'b0;
    tick();
    check("wr_ack_1clk", 32'(cpu_ack), 32'h0);

    // CPU read of lane 3, minimum latency.
    wait_phase(2'd2);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 19'h00003;
    mem_rdata = 32'h11223344;
    wait_ack(1'b0, 12, waited);
    check("rd_latency", 32'(waited),    32'd6);
    check("rd_rdata",   32'(cpu_rdata), 32'h11);
    cpu_req = 1'b0;
    tick();
    check("rd_ack_1clk",   32'(cpu_ack),   32'h0);
    check("rd_rdata_held", 32'(cpu_rdata), 32'h11);

    // Asynchronous reset at phase 1 of an owned CPU write slot.
    wait_phase(2'd2);
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 19'h0000D; cpu_wdata = 8'h5A;
    tick(); tick();
    check("mid_we_before_rst", 32'(mem_we), 32'h1);
    tick();
    #2 reset_n = 1'b0;
    #1;
    check("arst_mem_we",    32'(mem_we),          32'h0);
    check("arst_mem_be",    32'(mem_be),          32'h0);
    check("arst_mem_addr",  32'(mem_addr),        32'h0);
    check("arst_mem_wdata", mem_wdata,            32'h0);
    check("arst_cpu_rdata", 32'(cpu_rdata),       32'h0);
    check("arst_refresh",   32'(mem_refresh),     32'h0);
    check("arst_dvalid",    32'(disp_data_valid), 32'h0);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("arst_no_ack", 32'(cpu_ack), 32'h0);
    end
    reset_n = 1'b1;
    tick();
    check("post_rst_idle_ph2", 32'(mem_we), 32'h0);
    tick();
    check("post_rst_idle_ph3", 32'(mem_we), 32'h0);
    check("post_rst_no_ack",   32'(cpu_ack), 32'h0);
    tick();
    check("post_rst_grant_we",   32'(mem_we),   32'h1);
    check("post_rst_grant_addr", 32'(mem_addr), 32'h3);
    check("post_rst_grant_be",   32'(mem_be),   32'h2);
    wait_ack(1'b0, 8, waited);
    cpu_req = 1'b0;

    // Display window: three DISP slots while a CPU read is starved.
    wait_phase(2'd2);
    display_window = 1'b1; disp_addr = 17'd0;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 19'h00002;
    tick(); tick();
    for (int i = 0; i < 3; i++) begin
      check("disp_mem_addr", 32'(mem_addr), 32'(i));
      check("disp_mem_be",   32'(mem_be),   32'hF);
      check("disp_mem_we",   32'(mem_we),   32'h0);
      disp_addr = 17'(i + 1);
      mem_rdata = 32'hD0000000 + 32'(i);
      if (i == 2) display_window = 1'b0;
      repeat (4) tick();
      check("disp_valid",   32'(disp_data_valid), 32'h1);
      check("disp_data",    disp_data,            32'hD0000000 + 32'(i));
      check("disp_starved", 32'(cpu_ack),         32'h0);
    end
    check("after_win_be", 32'(mem_be), 32'h4);
    mem_rdata = 32'h77665544;
    wait_ack(1'b0, 8, waited);
    check("after_win_wait",  32'(waited),    32'd4);
    check("after_win_rdata", 32'(cpu_rdata), 32'h66);
    cpu_req = 1'b0;

    // Refresh slot at cx 720..723 inside an open window.
    wait_cx(10'd714);
    display_window = 1'b1; disp_addr = 17'h1ABCD; mem_rdata = 32'hCAFEF00D;
    tick(); tick();
    for (int c = 716; c <= 728; c++) begin
      check("ref_mem_refresh", 32'(mem_refresh),     (c >= 720 && c <= 723) ? 32'h1 : 32'h0);
      check("ref_disp_valid",  32'(disp_data_valid), (c == 720 || c == 728) ? 32'h1 : 32'h0);
      check("ref_mem_be",      32'(mem_be),          (c >= 720 && c <= 723) ? 32'h0 : 32'hF);
      tick();
    end
    display_window = 1'b0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
